// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch PC unit.
package fetch_pkg;

  typedef enum logic [1:0] {
    REQ  = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;
  localparam int unsigned INSTR_BYTES = 4;

  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_perf_counter.sv
// Consumed-instruction and stall-cycle counters for the fetch stage.
module fetch_perf_counter (
  input  logic        clock,
  input  logic        reset,
  input  logic        valid_out,
  input  logic        stall,
  output logic [31:0] fetch_count,
  output logic [31:0] stall_cycles
);

  logic [31:0] r_fetch_count;
  logic [31:0] r_stall_cycles;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_fetch_count  <= '0;
      r_stall_cycles <= '0;
    end else begin
      if (valid_out && !stall) r_fetch_count  <= r_fetch_count + 32'd1;
      if (valid_out && stall)  r_stall_cycles <= r_stall_cycles + 32'd1;
    end
  end

  assign fetch_count  = r_fetch_count;
  assign stall_cycles = r_stall_cycles;

endmodule

// File: rtl/fetch_pc_unit.sv
// PC generation and instruction fetch with one outstanding request.
// Define FETCH_PERF_CNT_EN to add the fetch_count / stall_cycles outputs.
module fetch_pc_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = fetch_pkg::NOP_INSTR
) (
  input  logic        clock,
  input  logic        reset,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic [31:0] instruction,
  output logic [31:0] program_counter,
  output logic        valid_out
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] fetch_count,
  output logic [31:0] stall_cycles
`endif
);

  import fetch_pkg::*;

  fetch_state_t r_state;
  logic [31:0]  r_pc;
  logic [31:0]  r_inflight_pc;
  logic [31:0]  r_buf;
  logic         r_discard;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state       <= REQ;
      r_pc          <= RESET_PC;
      r_inflight_pc <= '0;
      r_buf         <= NOP_INSTR;
      r_discard     <= 1'b0;
    end else if (redirect) begin
      r_pc  <= align_word(redirect_pc);
      r_buf <= NOP_INSTR;
      // A request already accepted must have its late response swallowed.
      if (r_state == WAIT && !imem_rsp_valid) begin
        r_discard <= 1'b1;
      end else begin
        r_discard <= 1'b0;
        r_state   <= REQ;
      end
    end else begin
      case (r_state)
        REQ: begin
          if (imem_req_ready) begin
            r_inflight_pc <= r_pc;
            r_pc          <= r_pc + 32'(INSTR_BYTES);
            r_state       <= WAIT;
          end
        end
        WAIT: begin
          if (imem_rsp_valid) begin
            if (r_discard) begin
              r_discard <= 1'b0;
              r_state   <= REQ;
            end else if (stall) begin
              r_buf   <= imem_rsp_data;
              r_state <= HOLD;
            end else begin
              r_state <= REQ;
            end
          end
        end
        HOLD: begin
          if (!stall) r_state <= REQ;
        end
        default: r_state <= REQ;
      endcase
    end
  end

  always_comb begin
    imem_req_valid = 1'b0;
    valid_out      = 1'b0;
    instruction    = NOP_INSTR;
    case (r_state)
      REQ:  imem_req_valid = !redirect && !reset;
      WAIT: begin
        if (imem_rsp_valid && !r_discard && !redirect) begin
          valid_out   = 1'b1;
          instruction = imem_rsp_data;
        end
      end
      HOLD: begin
        if (!redirect) begin
          valid_out   = 1'b1;
          instruction = r_buf;
        end
      end
      default: ;
    endcase
  end

  assign imem_req_addr   = r_pc;
  assign program_counter = r_inflight_pc;

`ifdef FETCH_PERF_CNT_EN
  fetch_perf_counter u_perf (
    .clock        (clock),
    .reset        (reset),
    .valid_out    (valid_out),
    .stall        (stall),
    .fetch_count  (fetch_count),
    .stall_cycles (stall_cycles)
  );
`endif

endmodule
